// File: rtl/prog_loader_if.sv
// Byte-stream handshake carrying program bytes into the loader.
// The master offers bytes; the slave (prog_loader) accepts them when in_ready is high.
interface prog_loader_if #(
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Programming-mode controller: streams program bytes into CPU RAM over the shared bus
// using the MAR-in / RAM-in strobes, then pulses a CPU reset so execution restarts at 0.
module prog_loader #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int RST_PULSE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_abort,
  prog_loader_if.slave      in_if,
  output logic              prog_mode,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              mi,
  output logic              ri,
  output logic              cpu_rst,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (RST_PULSE < 2) ? 1 : $clog2(RST_PULSE + 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RST_PULSE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_ADDR_PH,
    S_DATA_PH,
    S_NEXT,
    S_RELEASE
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] data_reg;
  logic              last_q;
  logic              start_q;
  logic              done_q;
  logic [CNT_W-1:0]  rst_cnt;
  logic              start;

  assign start = load_start & ~start_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the reset branch is asynchronous via the sensitivity list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (start) state_nxt = S_WAIT_BYTE;
      S_WAIT_BYTE: begin
        if (in_if.in_valid)  state_nxt = S_ADDR_PH;
        else if (load_abort) state_nxt = S_RELEASE;
      end
      S_ADDR_PH:   state_nxt = S_DATA_PH;
      S_DATA_PH:   state_nxt = S_NEXT;
      S_NEXT:      state_nxt = (last_q || addr == ADDR_MAX) ? S_RELEASE : S_WAIT_BYTE;
      S_RELEASE:   if (rst_cnt == CNT_LAST) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // The write address never wraps: the top address always exits through RELEASE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      data_reg <= '0;
      last_q   <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      rst_cnt  <= '0;
    end else begin
      start_q <= load_start;
      done_q  <= (state == S_RELEASE) && (state_nxt == S_IDLE);
      if (state == S_IDLE && start) addr <= '0;
      if (state == S_NEXT && state_nxt == S_WAIT_BYTE) addr <= addr + 1'b1;
      if (state == S_WAIT_BYTE && in_if.in_valid) begin
        data_reg <= in_if.in_data;
        last_q   <= in_if.in_last;
      end
      rst_cnt <= (state == S_RELEASE && state_nxt == S_RELEASE) ? rst_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    prog_mode      = 1'b0;
    in_if.in_ready = 1'b0;
    bus_out        = '0;
    bus_oe         = 1'b0;
    mi             = 1'b0;
    ri             = 1'b0;
    cpu_rst        = 1'b0;
    busy           = (state != S_IDLE);
    unique case (state)
      S_IDLE: ;
      S_WAIT_BYTE: begin
        prog_mode      = 1'b1;
        in_if.in_ready = 1'b1;
      end
      S_ADDR_PH: begin
        prog_mode = 1'b1;
        bus_out   = DATA_W'(addr);
        bus_oe    = 1'b1;
        mi        = 1'b1;
      end
      S_DATA_PH: begin
        prog_mode = 1'b1;
        bus_out   = data_reg;
        bus_oe    = 1'b1;
        ri        = 1'b1;
      end
      S_NEXT:    prog_mode = 1'b1;
      S_RELEASE: begin
        prog_mode = 1'b1;
        cpu_rst   = 1'b1;
      end
      default: ;
    endcase
  end

  assign done = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scripted scenarios plus randomized loads,
// checked against expected phase-by-phase outputs derived from the load rules.
module tb_prog_loader;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int RST_PULSE = 2;
  localparam int DEPTH     = 1 << ADDR_W;

  // Control vector: {prog_mode, in_ready, bus_oe, mi, ri, cpu_rst, busy, done}
  localparam logic [7:0] C_IDLE = 8'b0000_0000;
  localparam logic [7:0] C_DONE = 8'b0000_0001;
  localparam logic [7:0] C_WAIT = 8'b1100_0010;
  localparam logic [7:0] C_ADDR = 8'b1011_0010;
  localparam logic [7:0] C_DATA = 8'b1010_1010;
  localparam logic [7:0] C_NEXT = 8'b1000_0010;
  localparam logic [7:0] C_REL  = 8'b1000_0110;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_start = 1'b0;
  logic              load_abort = 1'b0;
  logic              prog_mode, bus_oe, mi, ri, cpu_rst, busy, done;
  logic [DATA_W-1:0] bus_out;
  logic [ADDR_W-1:0] addr;

  prog_loader_if #(.DATA_W(DATA_W)) in_if ();

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_PULSE(RST_PULSE)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_abort(load_abort),
    .in_if(in_if), .prog_mode(prog_mode), .bus_out(bus_out), .bus_oe(bus_oe),
    .mi(mi), .ri(ri), .cpu_rst(cpu_rst), .addr(addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int inv_err = 0;
  int ri_cnt = 0;
  int rst_cycles = 0;

  function automatic logic [7:0] ctl();
    return {prog_mode, in_if.in_ready, bus_oe, mi, ri, cpu_rst, busy, done};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Bus-ownership invariants observed on every cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (ctl() !== 8'h00 || bus_out !== '0 || addr !== '0) inv_err++;
    end else begin
      if ((mi && ri) || ((mi || ri) && !prog_mode) || (bus_oe !== (mi || ri))) inv_err++;
      if (cpu_rst) rst_cycles++;
      if (ri) ri_cnt++;
    end
  end

  // Entered at a negedge with the loader in WAIT_BYTE; leaves at the negedge after NEXT.
  task automatic send_byte(input logic [7:0] b, input bit last, input int exp_addr,
                           input bit abort_in_data, input bit keep_valid, input string name);
    checks++;
    if (ctl() !== C_WAIT) $display("FAIL %s wait a%0d: got %b want %b", name, exp_addr, ctl(), C_WAIT);
    else passed++;
    in_if.in_valid = 1'b1;
    in_if.in_data  = b;
    in_if.in_last  = last;
    step();
    if (!keep_valid) in_if.in_valid = 1'b0;
    in_if.in_data = 8'($urandom);
    in_if.in_last = 1'($urandom);
    checks++;
    if ({ctl(), bus_out, addr} !== {C_ADDR, 8'(exp_addr), 4'(exp_addr)})
      $display("FAIL %s addr_ph a%0d: got %b/%h/%h want %b/%h/%h", name, exp_addr,
               ctl(), bus_out, addr, C_ADDR, 8'(exp_addr), 4'(exp_addr));
    else passed++;
    step();
    if (abort_in_data) load_abort = 1'b1;
    checks++;
    if ({ctl(), bus_out} !== {C_DATA, b})
      $display("FAIL %s data_ph a%0d: got %b/%h want %b/%h", name, exp_addr, ctl(), bus_out, C_DATA, b);
    else passed++;
    step();
    checks++;
    if (ctl() !== C_NEXT) $display("FAIL %s next a%0d: got %b want %b", name, exp_addr, ctl(), C_NEXT);
    else passed++;
    step();
  endtask

  // Entered at the first RELEASE negedge.
  task automatic expect_release(input int exp_addr, input string name);
    for (int k = 0; k < RST_PULSE; k++) begin
      checks++;
      if (ctl() !== C_REL) $display("FAIL %s release%0d: got %b want %b", name, k, ctl(), C_REL);
      else passed++;
      step();
    end
    checks++;
    if ({ctl(), addr} !== {C_DONE, 4'(exp_addr)})
      $display("FAIL %s done: got %b/%h want %b/%h", name, ctl(), addr, C_DONE, 4'(exp_addr));
    else passed++;
    step();
    checks++;
    if ({ctl(), addr, bus_out} !== {C_IDLE, 4'(exp_addr), 8'h00})
      $display("FAIL %s idle: got %b/%h/%h want %b/%h/00", name, ctl(), addr, bus_out, C_IDLE, 4'(exp_addr));
    else passed++;
  endtask

  // A complete load of n random bytes; the load must end by in_last or by filling RAM.
  task automatic do_load(input int n, input bit set_last, input int gap_min, input int gap_max,
                         input bit hold_valid, input string name);
    int r0;
    int e0;
    int c0;
    int g;
    r0 = ri_cnt; e0 = inv_err; c0 = rst_cycles;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      g = hold_valid ? 0 : int'($urandom_range(gap_max, gap_min));
      for (int j = 0; j < g; j++) begin
        in_if.in_valid = 1'b0;
        checks++;
        if ({ctl(), addr} !== {C_WAIT, 4'(i)})
          $display("FAIL %s gap b%0d: got %b/%h want %b/%h", name, i, ctl(), addr, C_WAIT, 4'(i));
        else passed++;
        step();
      end
      send_byte(8'($urandom), set_last && (i == n - 1), i, 1'b0, hold_valid, name);
    end
    in_if.in_valid = 1'b0;
    expect_release(n - 1, name);
    checks++;
    if ({ri_cnt - r0, rst_cycles - c0, inv_err - e0} !== {n, RST_PULSE, 0})
      $display("FAIL %s totals: writes %0d rst %0d inv %0d want %0d %0d 0",
               name, ri_cnt - r0, rst_cycles - c0, inv_err - e0, n, RST_PULSE);
    else passed++;
  endtask

  task automatic test_reset();
    step();
    checks++;
    if ({ctl(), addr, bus_out} !== '0)
      $display("FAIL reset held: got %b/%h/%h want all zero", ctl(), addr, bus_out);
    else passed++;
    rst = 1'b0;
    step();
    checks++;
    if ({ctl(), addr, bus_out} !== '0)
      $display("FAIL reset first_idle: got %b/%h/%h want all zero", ctl(), addr, bus_out);
    else passed++;
  endtask

  task automatic test_basic();
    logic [7:0] prog [3];
    prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'hE0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(prog[i], i == 2, i, 1'b0, 1'b1, "basic");
    in_if.in_valid = 1'b0;
    expect_release(2, "basic");
  endtask

  task automatic test_full();
    do_load(DEPTH, 1'b0, 0, 0, 1'b1, "full");
    in_if.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({ctl(), addr} !== {C_IDLE, 4'(DEPTH - 1)})
        $display("FAIL full no_17th%0d: got %b/%h want %b/%h", k, ctl(), addr, C_IDLE, 4'(DEPTH - 1));
      else passed++;
    end
    in_if.in_valid = 1'b0;
  endtask

  task automatic test_gaps();
    do_load(4, 1'b1, 5, 5, 1'b0, "gaps");
  endtask

  task automatic test_abort();
    int r0;
    // Abort raised in DATA_PH of byte 2 and held: byte 2 completes, then release.
    r0 = ri_cnt;
    load_start = 1'b1; step(); load_start = 1'b0;
    send_byte(8'h5A, 1'b0, 0, 1'b0, 1'b0, "abort_a");
    send_byte(8'hA5, 1'b0, 1, 1'b1, 1'b0, "abort_a");
    checks++;
    if ({ctl(), addr} !== {C_WAIT, 4'd2})
      $display("FAIL abort_a wait: got %b/%h want %b/2", ctl(), addr, C_WAIT);
    else passed++;
    step();
    load_abort = 1'b0;
    expect_release(2, "abort_a");
    checks++;
    if (ri_cnt - r0 !== 2) $display("FAIL abort_a writes: got %0d want 2", ri_cnt - r0);
    else passed++;
    // Abort together with valid in WAIT_BYTE: the byte wins.
    load_start = 1'b1; step(); load_start = 1'b0;
    load_abort = 1'b1;
    send_byte(8'hC3, 1'b1, 0, 1'b0, 1'b0, "abort_b");
    load_abort = 1'b0;
    expect_release(0, "abort_b");
    // Abort before any byte: nothing written, reset still pulsed.
    r0 = ri_cnt;
    load_start = 1'b1; step(); load_start = 1'b0;
    load_abort = 1'b1; step(); load_abort = 1'b0;
    expect_release(0, "abort_c");
    checks++;
    if (ri_cnt - r0 !== 0) $display("FAIL abort_c writes: got %0d want 0", ri_cnt - r0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int c0;
    c0 = rst_cycles;
    load_start = 1'b1; step(); load_start = 1'b0;
    in_if.in_valid = 1'b1; in_if.in_data = 8'h77; in_if.in_last = 1'b0;
    step();
    in_if.in_valid = 1'b0;
    step();
    checks++;
    if (ctl() !== C_DATA) $display("FAIL rst_mid pre: got %b want %b", ctl(), C_DATA);
    else passed++;
    load_start = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ctl(), addr, bus_out} !== '0)
      $display("FAIL rst_mid async: got %b/%h/%h want all zero", ctl(), addr, bus_out);
    else passed++;
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if ({ctl(), addr, rst_cycles - c0} !== {C_WAIT, 4'd0, 0})
      $display("FAIL rst_mid restart: got %b/%h/%0d want %b/0/0", ctl(), addr, rst_cycles - c0, C_WAIT);
    else passed++;
    load_start = 1'b0;
    load_abort = 1'b1; step(); load_abort = 1'b0;
    expect_release(0, "rst_mid");
  endtask

  task automatic test_retrigger();
    load_start = 1'b1; step();
    load_start = 1'b0; step();
    load_start = 1'b1;
    send_byte(8'h11, 1'b0, 0, 1'b0, 1'b0, "retrig");
    load_start = 1'b0;
    send_byte(8'h22, 1'b0, 1, 1'b0, 1'b0, "retrig");
    load_start = 1'b1;
    send_byte(8'h33, 1'b1, 2, 1'b0, 1'b0, "retrig");
    expect_release(2, "retrig");
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (ctl() !== C_IDLE) $display("FAIL retrig held%0d: got %b want %b", k, ctl(), C_IDLE);
      else passed++;
    end
    load_start = 1'b0; step();
    load_start = 1'b1; step();
    checks++;
    if ({ctl(), addr} !== {C_WAIT, 4'd0})
      $display("FAIL retrig rise: got %b/%h want %b/0", ctl(), addr, C_WAIT);
    else passed++;
    load_start = 1'b0;
    load_abort = 1'b1; step(); load_abort = 1'b0;
    expect_release(0, "retrig_end");
  endtask

  task automatic test_random();
    int n;
    bit lst;
    for (int t = 0; t < 6; t++) begin
      n   = int'($urandom_range(DEPTH, 1));
      lst = (n < DEPTH) ? 1'b1 : 1'($urandom);
      do_load(n, lst, 0, 3, 1'($urandom), "random");
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    in_if.in_last  = 1'b0;
    test_reset();
    test_basic();
    step();
    test_full();
    step();
    test_gaps();
    step();
    test_abort();
    step();
    test_reset_mid();
    step();
    test_retrigger();
    step();
    test_random();
    checks++;
    if (inv_err !== 0) $display("FAIL bus_invariants: got %0d violations want 0", inv_err);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Programming-mode controller for the 8-bit CPU.
- Accepts program bytes over a valid/ready byte interface and sequences them into the 16-byte RAM over the shared bus, using the same MAR-in (mi) and RAM-in (ri) strobes the instruction decoder uses.
- While loading, asserts prog_mode so the decoder halts and releases the bus.
- On completion, pulses a CPU reset so execution restarts at address 0.

Parameters:
- ADDR_W, 4, RAM address width; the program holds up to 2**ADDR_W bytes.
- DATA_W, 8, bus and program byte width.
- RST_PULSE, 2, number of cycles cpu_rst is held high on release (minimum 1).

Ports:
- clk  input  1  block clock; all state updates on posedge clk.
- rst  input  1  asynchronous, active-high reset.
- load_start  input  1  request to begin a load; rising-edge detected.
- load_abort  input  1  end the load early; honoured only in WAIT_BYTE.
- in_valid  input  1  in_data holds a program byte.
- in_data  input  DATA_W  program byte.
- in_last  input  1  qualifies in_data as the final byte.
- in_ready  output  1  loader can accept a byte this cycle.
- prog_mode  output  1  CPU hold; decoder halts while high.
- bus_out  output  DATA_W  value driven onto the shared bus.
- bus_oe  output  1  bus_out is valid and owns the bus.
- mi  output  1  memory-address-register load strobe.
- ri  output  1  RAM write strobe.
- cpu_rst  output  1  reset pulse to the CPU after a load.
- addr  output  ADDR_W  current write address.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse when loading finishes.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, addr=0, data_reg=0, start_q=0, last_q=0, rst_cnt=0.
  - All outputs are 0 during reset and in the first IDLE cycle.
- Start detection:
  - start_q registers load_start every cycle.
  - A start is load_start & ~start_q, acted on only in IDLE.
  - If load_start is already high at reset release, the load starts on the first clock edge.
  - Starts outside IDLE are ignored.
- Outputs are decoded from the registered state only (Moore), except done, which is registered.
- State machine:
  - IDLE: prog_mode=0.
    - On start: addr<=0 -> WAIT_BYTE.
  - WAIT_BYTE: prog_mode=1, in_ready=1.
    - If in_valid: data_reg<=in_data, last_q<=in_last -> ADDR_PH.
    - Else if load_abort: -> RELEASE.
    - in_valid takes priority over load_abort in the same cycle.
  - ADDR_PH: bus_out={zeros, addr}, bus_oe=1, mi=1 -> DATA_PH.
  - DATA_PH: bus_out=data_reg, bus_oe=1, ri=1 -> NEXT.
  - NEXT: bus_oe=0.
    - If last_q=1 or addr=2**ADDR_W-1: -> RELEASE (addr holds).
    - Else: addr<=addr+1 -> WAIT_BYTE.
  - RELEASE: prog_mode=1, cpu_rst=1 for exactly RST_PULSE cycles (rst_cnt counts).
    - Then -> IDLE, with done=1 on the first IDLE cycle.
- Timing:
  - Handshake at edge T gives ADDR_PH in T+1, DATA_PH in T+2, NEXT in T+3, and in_ready high again in T+4.
  - Maximum throughput is one byte per 4 cycles.
- Address rules:
  - addr never wraps during a load; writing the top address forces RELEASE regardless of in_last.
  - A full load is 2**ADDR_W bytes.
  - addr holds its final value in IDLE until the next start.
- Bus rules:
  - bus_oe is high only in ADDR_PH and DATA_PH.
  - mi and ri are never high together, and never high outside prog_mode=1.
- Abort rules:
  - load_abort in ADDR_PH, DATA_PH or NEXT is ignored; the current write completes.
  - An abort still held when the FSM returns to WAIT_BYTE is taken there.
  - Abort at WAIT_BYTE before any byte writes nothing, but still pulses cpu_rst.
- Reset mid-load returns immediately to IDLE with prog_mode=0 and no cpu_rst pulse; partially written RAM is left as is.
- in_data and in_last are sampled only on the handshake cycle.

Test Plan:
- rst, then load_start rise; send bytes 0x1E,0x2F,0xE0 (in_last on 0xE0), in_valid always high -> mi pulses with bus_out 0x00,0x01,0x02; ri pulses with bus_out 0x1E,0x2F,0xE0; in_ready high every 4th cycle; cpu_rst high 2 cycles; done 1 cycle; prog_mode low after.
- Full load of 16 bytes 0x00..0x0F, in_last never set -> final write at addr 0xF; RELEASE entered automatically; addr stays 0xF; no 17th in_ready.
- in_valid gaps (valid low 5 cycles between bytes) -> FSM waits in WAIT_BYTE with in_ready=1; no mi/ri/bus_oe while waiting.
- load_abort asserted in DATA_PH of byte 2 and held -> byte 2 still written; then RELEASE; cpu_rst pulse; done. Same cycle in_valid=1 with load_abort=1 in WAIT_BYTE -> byte accepted.
- rst asserted during DATA_PH -> all outputs 0 asynchronously; state IDLE; load_start held high across reset -> new load starts on first edge after release.
- load_start pulsed while busy -> ignored; after done, load_start held high -> no retrigger until it falls and rises again.
